// File: rtl/perf_counter_reader.sv
// perf_counter_reader
// Request/response read port for the three 20-bit event counters.
// A SNAPSHOT copies all three live counters into shadow registers on one edge,
// so reads of the shadows always return values that belong together.
// Wrap-around of each live counter is detected every cycle and recorded in a
// sticky overflow bit. READ_OVF returns those bits and then clears them.
module perf_counter_reader #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] instr_cnt,
    input  logic [CNT_W-1:0] mem_acc_cnt,
    input  logic [CNT_W-1:0] mem_corr_cnt,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] resp_data,
    output logic             resp_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [2:0] OP_RD_INSTR = 3'd0;
    localparam logic [2:0] OP_RD_ACC   = 3'd1;
    localparam logic [2:0] OP_RD_CORR  = 3'd2;
    localparam logic [2:0] OP_SNAPSHOT = 3'd3;
    localparam logic [2:0] OP_READ_OVF = 3'd4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] sh_instr_q, sh_instr_d;
    logic [CNT_W-1:0] sh_acc_q, sh_acc_d;
    logic [CNT_W-1:0] sh_corr_q, sh_corr_d;
    logic [2:0]       ovf_q, ovf_d;
    logic [CNT_W-1:0] prev_instr_q, prev_acc_q, prev_corr_q;
    logic [2:0]       wrap;
    logic             accept;

    // A wrap is the step from all-ones straight to zero, seen against last cycle's value.
    always_comb begin
        wrap[0] = (prev_instr_q == {CNT_W{1'b1}}) && (instr_cnt    == '0);
        wrap[1] = (prev_acc_q   == {CNT_W{1'b1}}) && (mem_acc_cnt  == '0);
        wrap[2] = (prev_corr_q  == {CNT_W{1'b1}}) && (mem_corr_cnt == '0);
    end

    assign accept     = (state_q == IDLE) && req_valid;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    // Next state: execute the op on the accept edge, hold the response until it is taken.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        sh_instr_d  = sh_instr_q;
        sh_acc_d    = sh_acc_q;
        sh_corr_d   = sh_corr_q;
        ovf_d       = ovf_q | wrap;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RESP;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    case (req_op)
                        OP_RD_INSTR: resp_data_d = sh_instr_q;
                        OP_RD_ACC:   resp_data_d = sh_acc_q;
                        OP_RD_CORR:  resp_data_d = sh_corr_q;
                        OP_SNAPSHOT: begin
                            sh_instr_d = instr_cnt;
                            sh_acc_d   = mem_acc_cnt;
                            sh_corr_d  = mem_corr_cnt;
                        end
                        OP_READ_OVF: begin
                            // Return the flags as they were, but keep any wrap landing on this edge.
                            resp_data_d = {{(CNT_W-3){1'b0}}, ovf_q};
                            ovf_d       = wrap;
                        end
                        default: resp_err_d = 1'b1;
                    endcase
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shadow, overflow and previous-value registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            sh_instr_q   <= '0;
            sh_acc_q     <= '0;
            sh_corr_q    <= '0;
            ovf_q        <= '0;
            prev_instr_q <= '0;
            prev_acc_q   <= '0;
            prev_corr_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            sh_instr_q   <= sh_instr_d;
            sh_acc_q     <= sh_acc_d;
            sh_corr_q    <= sh_corr_d;
            ovf_q        <= ovf_d;
            prev_instr_q <= instr_cnt;
            prev_acc_q   <= mem_acc_cnt;
            prev_corr_q  <= mem_corr_cnt;
        end
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Testbench for perf_counter_reader.
// Directed scenarios followed by randomized transactions, all checked against a
// transaction-level model of shadows and sticky overflow flags.
module tb_perf_counter_reader;

    localparam int W = 20;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] instrCnt = '0;
    logic [W-1:0] accCnt = '0;
    logic [W-1:0] corrCnt = '0;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic [2:0]   reqOp = 3'd0;
    logic         respValid;
    logic         respReady = 1'b0;
    logic [W-1:0] respData;
    logic         respErr;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] mSh [3];
    logic [W-1:0] mPrev [3];
    logic [2:0]   mOvf;
    int           liveMode = 0;

    perf_counter_reader #(.CNT_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_cnt   (instrCnt),
        .mem_acc_cnt (accCnt),
        .mem_corr_cnt(corrCnt),
        .req_valid   (reqValid),
        .req_ready   (reqReady),
        .req_op      (reqOp),
        .resp_valid  (respValid),
        .resp_ready  (respReady),
        .resp_data   (respData),
        .resp_err    (respErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mSh[i]   = '0;
            mPrev[i] = '0;
        end
        mOvf = '0;
    endtask

    // Move the live counters according to the current mode.
    task automatic driveLive();
        case (liveMode)
            1: instrCnt = instrCnt + 1'b1;
            2: begin
                int r;
                r = $urandom_range(0, 7);
                instrCnt = (r == 0) ? ONES : (r == 1) ? '0 : W'($urandom);
                r = $urandom_range(0, 7);
                accCnt = (r == 0) ? ONES : (r == 1) ? '0 : W'($urandom);
                r = $urandom_range(0, 7);
                corrCnt = (r == 0) ? ONES : (r == 1) ? '0 : W'($urandom);
            end
            default: ;
        endcase
    endtask

    // One clock edge; model applies wraps and, if accepted, the op.
    task automatic tick(input bit accept, input logic [2:0] op,
                        output logic [W-1:0] expData, output logic expErr);
        logic [W-1:0] live [3];
        logic [2:0]   wrap;
        @(posedge clk);
        live[0] = instrCnt;
        live[1] = accCnt;
        live[2] = corrCnt;
        for (int i = 0; i < 3; i++) begin
            wrap[i]  = (mPrev[i] == ONES) && (live[i] == '0);
            mPrev[i] = live[i];
        end
        expData = '0;
        expErr  = 1'b0;
        if (accept) begin
            if (op <= 3'd2) expData = mSh[op];
            else if (op == 3'd3) for (int i = 0; i < 3; i++) mSh[i] = live[i];
            else if (op == 3'd4) expData = W'(mOvf);
            else expErr = 1'b1;
        end
        if (accept && op == 3'd4) mOvf = wrap;
        else mOvf = mOvf | wrap;
        #1;
        driveLive();
    endtask

    task automatic idle(input int n);
        logic [W-1:0] d;
        logic e;
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, d, e);
    endtask

    // Issue one request, optionally stall the response, and check the handshake.
    task automatic applyStimulus(input logic [2:0] op, input int hold, input bit keepValid,
                                 output logic [W-1:0] got);
        logic [W-1:0] expD, d2;
        logic expE, e2;
        reqValid = 1'b1;
        reqOp    = op;
        tick(1'b1, op, expD, expE);
        if (!keepValid) reqValid = 1'b0;
        got = respData;
        checkOutput("resp_valid after accept", respValid, 1);
        checkOutput("req_ready in RESP", reqReady, 0);
        checkOutput($sformatf("resp_data op%0d", op), respData, expD);
        checkOutput($sformatf("resp_err op%0d", op), respErr, expE);
        for (int i = 0; i < hold; i++) begin
            tick(1'b0, 3'd0, d2, e2);
            checkOutput("resp_valid held", respValid, 1);
            checkOutput("req_ready held low", reqReady, 0);
            checkOutput("resp_data stable", respData, expD);
        end
        respReady = 1'b1;
        tick(1'b0, 3'd0, d2, e2);
        respReady = 1'b0;
        reqValid  = 1'b0;
        checkOutput("resp_valid after handshake", respValid, 0);
        checkOutput("req_ready after handshake", reqReady, 1);
    endtask

    initial begin
        logic [W-1:0] got, snapVal;
        modelReset();
        #3;
        checkOutput("reset resp_valid", respValid, 0);
        checkOutput("reset resp_data", respData, 0);
        checkOutput("reset resp_err", respErr, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("req_ready after reset", reqReady, 1);

        // Snapshot then read each shadow
        instrCnt = 20'h00005; accCnt = 20'h00003; corrCnt = 20'h00001;
        applyStimulus(3'd3, 0, 1'b0, got);
        checkOutput("snapshot data", got, 0);
        applyStimulus(3'd0, 0, 1'b0, got); checkOutput("sh_instr", got, 20'h00005);
        applyStimulus(3'd1, 0, 1'b0, got); checkOutput("sh_acc", got, 20'h00003);
        applyStimulus(3'd2, 0, 1'b0, got); checkOutput("sh_corr", got, 20'h00001);

        // Snapshot of a moving counter
        instrCnt = 20'h00010;
        liveMode = 1;
        idle(2);
        snapVal = instrCnt;
        applyStimulus(3'd3, 0, 1'b0, got);
        applyStimulus(3'd0, 0, 1'b0, got); checkOutput("moving snap", got, snapVal);
        idle(3);
        applyStimulus(3'd0, 1, 1'b0, got); checkOutput("moving snap again", got, snapVal);
        liveMode = 0;

        // Memory access counter wrap
        accCnt = ONES; idle(1);
        accCnt = '0;   idle(1);
        applyStimulus(3'd4, 0, 1'b0, got); checkOutput("ovf acc", got, 20'h00002);
        applyStimulus(3'd4, 0, 1'b0, got); checkOutput("ovf cleared", got, 20'h00000);

        // Instruction wrap on the READ_OVF accept edge
        instrCnt = ONES; idle(1);
        instrCnt = '0;
        applyStimulus(3'd4, 0, 1'b0, got); checkOutput("ovf same-edge", got, 20'h00000);
        applyStimulus(3'd4, 0, 1'b0, got); checkOutput("ovf retained", got, 20'h00001);

        // Stalled response with request held valid
        applyStimulus(3'd1, 5, 1'b1, got);

        // Unsupported op leaves shadows unchanged
        applyStimulus(3'd6, 0, 1'b0, got); checkOutput("bad op data", got, 0);
        applyStimulus(3'd0, 0, 1'b0, got); checkOutput("sh after bad op", got, snapVal);

        // Reset while a response is pending
        reqValid = 1'b1; reqOp = 3'd0;
        @(posedge clk);
        #1 reqValid = 1'b0;
        checkOutput("pre-reset resp_valid", respValid, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("reset mid resp_valid", respValid, 0);
        checkOutput("reset mid resp_data", respData, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("req_ready after mid reset", reqReady, 1);
        applyStimulus(3'd0, 0, 1'b0, got); checkOutput("sh_instr cleared", got, 0);
        applyStimulus(3'd4, 0, 1'b0, got); checkOutput("ovf cleared by reset", got, 0);

        // Randomized transactions against the model
        liveMode = 2;
        for (int t = 0; t < 60; t++) begin
            idle($urandom_range(0, 2));
            applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end
        liveMode = 0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
